// File: rtl/mem_stage_ctrl_pkg.sv
// rtl/mem_stage_ctrl_pkg.sv - state encoding, funct3 modes, strobes and op legality for the memory stage
package mem_ctrl_pkg;

   localparam int MODE_W = 3;
   localparam int STRB_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [MODE_W-1:0] F3_B  = 3'b000;
   localparam logic [MODE_W-1:0] F3_H  = 3'b001;
   localparam logic [MODE_W-1:0] F3_W  = 3'b010;
   localparam logic [MODE_W-1:0] F3_BU = 3'b100;
   localparam logic [MODE_W-1:0] F3_HU = 3'b101;

   localparam logic [STRB_W-1:0] STRB_B = 4'b0001;
   localparam logic [STRB_W-1:0] STRB_H = 4'b0011;
   localparam logic [STRB_W-1:0] STRB_W_ALL = 4'b1111;

   function automatic logic op_legal(input logic rd, input logic wr,
                                     input logic [MODE_W-1:0] mode, input logic [1:0] a);
      logic ok;
      ok = !(rd && wr);
      case (mode)
         F3_B, F3_BU: ;
         F3_H, F3_HU: if (a[0]) ok = 1'b0;
         F3_W:        if (a != 2'b00) ok = 1'b0;
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - pipeline and data-memory signals of the memory stage controller
interface mem_stage_ctrl_if
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                mem_read_i;
   logic                mem_write_i;
   logic [ADDR_W-1:0]   addr_i;
   logic [DATA_W-1:0]   wdata_i;
   logic [MODE_W-1:0]   mode_i;
   logic                flush_i;
   logic                stall_o;
   logic                req_valid_o;
   logic                req_ready_i;
   logic                req_we_o;
   logic [ADDR_W-1:0]   req_addr_o;
   logic [DATA_W-1:0]   req_wdata_o;
   logic [STRB_W-1:0]   req_wstrb_o;
   logic                rsp_valid_i;
   logic [DATA_W-1:0]   rsp_rdata_i;
   logic [DATA_W-1:0]   load_data_o;
   logic                load_valid_o;
   logic                err_o;

   modport slave (
      input  mem_read_i, mem_write_i, addr_i, wdata_i, mode_i, flush_i,
      input  req_ready_i, rsp_valid_i, rsp_rdata_i,
      output stall_o, req_valid_o, req_we_o, req_addr_o, req_wdata_o, req_wstrb_o,
      output load_data_o, load_valid_o, err_o
   );

   modport master (
      output mem_read_i, mem_write_i, addr_i, wdata_i, mode_i, flush_i,
      output req_ready_i, rsp_valid_i, rsp_rdata_i,
      input  stall_o, req_valid_o, req_we_o, req_addr_o, req_wdata_o, req_wstrb_o,
      input  load_data_o, load_valid_o, err_o
   );

endinterface

// File: rtl/mem_stage_ctrl_load_align.sv
// rtl/mem_stage_ctrl_load_align.sv - load_align: byte/half extraction and extension of a raw read word
module load_align
   import mem_ctrl_pkg::*;
(
   input  logic [31:0]       rdata,
   input  logic [1:0]        addr_lo,
   input  logic [MODE_W-1:0] mode,
   output logic [31:0]       load_data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = 8'h00;
      case (addr_lo)
         2'd0: b = rdata[7:0];
         2'd1: b = rdata[15:8];
         2'd2: b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (mode)
         F3_B:    load_data = {{24{b[7]}}, b};
         F3_BU:   load_data = {24'h000000, b};
         F3_H:    load_data = {{16{h[15]}}, h};
         F3_HU:   load_data = {16'h0000, h};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - single-outstanding memory-stage sequencer with pipeline stall and lane alignment
// Optional watchdog: define MEM_TIMEOUT_EN.
module mem_stage_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
)(
   input logic             clk,
   input logic             rst_n,
   mem_stage_ctrl_if.slave bus
);

   logic [1:0]         state;
   logic               op;
   logic               legal;
   logic               accept;
   logic               timeout;
   logic               we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [1:0]         a_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [STRB_W-1:0]  strb_q;
   logic [MODE_W-1:0]  mode_q;
   logic               flushed_q;
   logic               err_q;
   logic [DATA_W-1:0]  load_data_q;
   logic [DATA_W-1:0]  aligned;
   logic [DATA_W-1:0]  st_data;
   logic [STRB_W-1:0]  st_strb;

   assign op     = bus.mem_read_i | bus.mem_write_i;
   assign legal  = op_legal(bus.mem_read_i, bus.mem_write_i, bus.mode_i, bus.addr_i[1:0]);
   // rst_n gate keeps stall_o low while reset is held with an op still presented
   assign accept = rst_n && (state == ST_IDLE) && op && legal && !bus.flush_i;

   always_comb begin
      st_strb = '0;
      st_data = '0;
      if (bus.mem_write_i) begin
         case (bus.mode_i[1:0])
            2'b00: begin
               st_strb = STRB_B << bus.addr_i[1:0];
               st_data = {4{bus.wdata_i[7:0]}};
            end
            2'b01: begin
               st_strb = STRB_H << bus.addr_i[1:0];
               st_data = {2{bus.wdata_i[15:0]}};
            end
            default: begin
               st_strb = STRB_W_ALL;
               st_data = bus.wdata_i;
            end
         endcase
      end
   end

   load_align u_load_align (
      .rdata     (bus.rsp_rdata_i),
      .addr_lo   (a_q),
      .mode      (mode_q),
      .load_data (aligned)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CNT_W-1:0] cnt_q;

   assign timeout = ((state == ST_REQ) || (state == ST_RESP)) &&
                    (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if ((state == ST_REQ && !bus.req_ready_i) || state == ST_RESP)
         cnt_q <= cnt_q + 1'b1;
      else
         cnt_q <= '0;
   end
`else
   logic [31:0] unused_timeout_cyc;
   assign unused_timeout_cyc = TIMEOUT_CYC;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         a_q         <= '0;
         wdata_q     <= '0;
         strb_q      <= '0;
         mode_q      <= '0;
         flushed_q   <= 1'b0;
         err_q       <= 1'b0;
         load_data_q <= '0;
      end else begin
         err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               flushed_q <= 1'b0;
               if (accept) begin
                  we_q    <= bus.mem_write_i;
                  addr_q  <= {bus.addr_i[ADDR_W-1:2], 2'b00};
                  a_q     <= bus.addr_i[1:0];
                  wdata_q <= st_data;
                  strb_q  <= st_strb;
                  mode_q  <= bus.mode_i;
                  state   <= ST_REQ;
               end else if (op && !bus.flush_i) begin
                  err_q <= 1'b1;
               end
            end
            ST_REQ: begin
               if (bus.flush_i) flushed_q <= 1'b1;
               if (bus.req_ready_i) begin
                  state <= ST_RESP;
               end else if (timeout) begin
                  // flushed_q doubles as the "no load result" marker for an abandoned op
                  flushed_q   <= 1'b1;
                  err_q       <= 1'b1;
                  load_data_q <= '0;
                  state       <= ST_DONE;
               end
            end
            ST_RESP: begin
               if (bus.flush_i) flushed_q <= 1'b1;
               if (bus.rsp_valid_i) begin
                  if (!we_q) load_data_q <= aligned;
                  state <= ST_DONE;
               end else if (timeout) begin
                  flushed_q   <= 1'b1;
                  err_q       <= 1'b1;
                  load_data_q <= '0;
                  state       <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.stall_o      = accept || (state == ST_REQ) || (state == ST_RESP);
   assign bus.req_valid_o  = (state == ST_REQ);
   assign bus.req_we_o     = we_q;
   assign bus.req_addr_o   = addr_q;
   assign bus.req_wdata_o  = wdata_q;
   assign bus.req_wstrb_o  = strb_q;
   assign bus.load_data_o  = load_data_q;
   assign bus.load_valid_o = (state == ST_DONE) && !we_q && !flushed_q;
   assign bus.err_o        = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed scoreboard bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
   import mem_ctrl_pkg::*;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [31:0] exp_load[$];

   mem_stage_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                               input logic [2:0] m);
      logic [31:0] sh;
      sh = w >> (8 * a);
      case (m)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'h0, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b101:  return {16'h0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] mode, input logic fl);
      bus.mem_read_i  = rd;
      bus.mem_write_i = wr;
      bus.addr_i      = addr;
      bus.wdata_i     = wd;
      bus.mode_i      = mode;
      bus.flush_i     = fl;
   endtask

   task automatic run_op(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] mode,
                         input int rwait, input logic [31:0] rdata, input logic fl_resp,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata);
      int st;
      st = 0;
      @(posedge clk); #1;
      drive(rd, wr, addr, wd, mode, 1'b0);
      bus.req_ready_i = 1'b0;
      bus.rsp_valid_i = 1'b0;
      if (rd && !fl_resp) exp_load.push_back(model_load(rdata, addr[1:0], mode));
      @(negedge clk);
      if (bus.stall_o) st++;
      chk({tag, "_idle_rv"}, 32'(bus.req_valid_o), 32'd0);
      for (int k = 0; k <= rwait; k++) begin
         @(posedge clk); #1;
         bus.req_ready_i = (k == rwait);
         @(negedge clk);
         if (bus.stall_o) st++;
         chk({tag, "_rv"}, 32'(bus.req_valid_o), 32'd1);
         chk({tag, "_we"}, 32'(bus.req_we_o), 32'(wr));
         chk({tag, "_addr"}, bus.req_addr_o, addr & 32'hFFFF_FFFC);
         if (wr) begin
            chk({tag, "_strb"}, 32'(bus.req_wstrb_o), 32'(e_strb));
            chk({tag, "_wdata"}, bus.req_wdata_o, e_wdata);
         end
      end
      @(posedge clk); #1;
      bus.req_ready_i = 1'b0;
      bus.rsp_valid_i = 1'b1;
      bus.rsp_rdata_i = rdata;
      bus.flush_i     = fl_resp;
      @(negedge clk);
      if (bus.stall_o) st++;
      chk({tag, "_resp_rv"}, 32'(bus.req_valid_o), 32'd0);
      @(posedge clk); #1;
      bus.rsp_valid_i = 1'b0;
      bus.rsp_rdata_i = 32'h5A5A_5A5A;
      bus.flush_i     = 1'b0;
      @(negedge clk);
      chk({tag, "_done_stall"}, 32'(bus.stall_o), 32'd0);
      chk({tag, "_lv"}, 32'(bus.load_valid_o), 32'(rd && !fl_resp));
      chk({tag, "_err"}, 32'(bus.err_o), 32'd0);
      if (bus.load_valid_o) begin
         chk({tag, "_sb_depth"}, 32'(exp_load.size()), 32'd1);
         if (exp_load.size() > 0) chk({tag, "_ldata"}, bus.load_data_o, exp_load.pop_front());
      end
      chk({tag, "_stall_cycles"}, 32'(st), 32'(rwait + 3));
   endtask

   task automatic idle_cycle;
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
      bus.req_ready_i = 1'b0;
      bus.rsp_valid_i = 1'b0;
   endtask

   task automatic bad_op(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [2:0] mode);
      @(posedge clk); #1;
      drive(rd, wr, addr, 32'h1234_5678, mode, 1'b0);
      @(negedge clk);
      chk({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
      chk({tag, "_rv0"}, 32'(bus.req_valid_o), 32'd0);
      idle_cycle();
      @(negedge clk);
      chk({tag, "_err"}, 32'(bus.err_o), 32'd1);
      chk({tag, "_rv1"}, 32'(bus.req_valid_o), 32'd0);
      idle_cycle();
      @(negedge clk);
      chk({tag, "_err_clr"}, 32'(bus.err_o), 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
      bus.req_ready_i = 1'b0;
      bus.rsp_valid_i = 1'b0;
      bus.rsp_rdata_i = 32'h0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_stall", 32'(bus.stall_o), 32'd0);
      chk("rst_rv", 32'(bus.req_valid_o), 32'd0);
      chk("rst_lv", 32'(bus.load_valid_o), 32'd0);
      chk("rst_err", 32'(bus.err_o), 32'd0);
      chk("rst_ldata", bus.load_data_o, 32'd0);

      run_op("lw",  1, 0, 32'h100, 32'h0, F3_W,  0, 32'hDEADBEEF, 0, 4'h0, 32'h0);
      run_op("lb",  1, 0, 32'h103, 32'h0, F3_B,  0, 32'h80112233, 0, 4'h0, 32'h0);
      run_op("lbu", 1, 0, 32'h103, 32'h0, F3_BU, 0, 32'h80112233, 0, 4'h0, 32'h0);
      run_op("lh",  1, 0, 32'h102, 32'h0, F3_H,  1, 32'h80112233, 0, 4'h0, 32'h0);
      run_op("lhu", 1, 0, 32'h102, 32'h0, F3_HU, 0, 32'h80112233, 0, 4'h0, 32'h0);
      run_op("lb1", 1, 0, 32'h201, 32'h0, F3_B,  0, 32'h00007F00, 0, 4'h0, 32'h0);
      run_op("sb",  0, 1, 32'h101, 32'h000000AB, F3_B, 5, 32'h0, 0, 4'b0010, 32'hABABABAB);
      run_op("sh",  0, 1, 32'h102, 32'h1234CDEF, F3_H, 2, 32'h0, 0, 4'b1100, 32'hCDEFCDEF);
      run_op("sw",  0, 1, 32'h104, 32'hCAFEF00D, F3_W, 0, 32'h0, 0, 4'b1111, 32'hCAFEF00D);
      idle_cycle();

      bad_op("lw_mis", 1, 0, 32'h102, F3_W);
      bad_op("lh_mis", 1, 0, 32'h101, F3_H);
      bad_op("mode3",  1, 0, 32'h100, 3'b011);
      bad_op("rdwr",   1, 1, 32'h100, F3_W);

      run_op("lw_fl", 1, 0, 32'h100, 32'h0, F3_W, 0, 32'h11111111, 1, 4'h0, 32'h0);
      run_op("lw_af", 1, 0, 32'h104, 32'h0, F3_W, 0, 32'h22222222, 0, 4'h0, 32'h0);

      @(posedge clk); #1;
      drive(1'b0, 1'b1, 32'h108, 32'h33333333, F3_W, 1'b1);
      @(negedge clk);
      chk("sw_fl_stall", 32'(bus.stall_o), 32'd0);
      idle_cycle();
      @(negedge clk);
      chk("sw_fl_rv", 32'(bus.req_valid_o), 32'd0);
      chk("sw_fl_err", 32'(bus.err_o), 32'd0);

      @(posedge clk); #1;
      drive(1'b0, 1'b1, 32'h10C, 32'h44444444, F3_W, 1'b0);
      @(negedge clk);
      chk("rreq_stall", 32'(bus.stall_o), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rreq_rv", 32'(bus.req_valid_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rreq_async_rv", 32'(bus.req_valid_o), 32'd0);
      chk("rreq_async_stall", 32'(bus.stall_o), 32'd0);
      chk("rreq_async_we", 32'(bus.req_we_o), 32'd0);
      chk("rreq_async_addr", bus.req_addr_o, 32'd0);
      chk("rreq_async_wdata", bus.req_wdata_o, 32'd0);
      chk("rreq_async_strb", 32'(bus.req_wstrb_o), 32'd0);
      chk("rreq_async_ldata", bus.load_data_o, 32'd0);
      chk("rreq_async_lv", 32'(bus.load_valid_o), 32'd0);
      chk("rreq_async_err", 32'(bus.err_o), 32'd0);
      idle_cycle();
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rreq_after_rv", 32'(bus.req_valid_o), 32'd0);

`ifdef MEM_TIMEOUT_EN
      run_op("lw_pre", 1, 0, 32'h120, 32'h0, F3_W, 0, 32'h77777777, 0, 4'h0, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 32'h110, 32'h0, F3_W, 1'b0);
      @(posedge clk); #1;
      bus.req_ready_i = 1'b1;
      @(negedge clk);
      chk("to_rv", 32'(bus.req_valid_o), 32'd1);
      @(posedge clk); #1;
      bus.req_ready_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("to_wait%0d_stall", k), 32'(bus.stall_o), 32'd1);
         chk($sformatf("to_wait%0d_err", k), 32'(bus.err_o), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("to_err", 32'(bus.err_o), 32'd1);
      chk("to_lv", 32'(bus.load_valid_o), 32'd0);
      chk("to_ldata", bus.load_data_o, 32'd0);
      chk("to_stall", 32'(bus.stall_o), 32'd0);
      idle_cycle();
      @(negedge clk);
      chk("to_idle_err", 32'(bus.err_o), 32'd0);
      chk("to_idle_rv", 32'(bus.req_valid_o), 32'd0);

      @(posedge clk); #1;
      drive(1'b0, 1'b1, 32'h114, 32'h55555555, F3_W, 1'b0);
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("toreq_rv", 32'(bus.req_valid_o), 32'd0);
      chk("toreq_err", 32'(bus.err_o), 32'd1);
      idle_cycle();
`endif

      chk("sb_drain", 32'(exp_load.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
